// File: rtl/comparator_minmax_stream_pkg.sv
// Shared constants and FSM state encoding for the min/max stream sink.
package comparator_minmax_stream_pkg;

  localparam int unsigned SIZE_DEF  = 32;
  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/comparator.sv
// Unsigned magnitude comparator producing equal/lower/greater flags for a against b.
module comparator
  import comparator_minmax_stream_pkg::*;
#(
  parameter int unsigned SIZE = SIZE_DEF
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic            equal,
  output logic            lower,
  output logic            greater
);

  assign equal   = (a == b);
  assign lower   = (a < b);
  assign greater = (a > b);

endmodule

// File: rtl/comparator_minmax_stream.sv
// Streaming sink tracking running min/max, first-occurrence indices and beat count per packet.
module comparator_minmax_stream
  import comparator_minmax_stream_pkg::*;
#(
  parameter int unsigned SIZE  = SIZE_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIZE-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIZE-1:0]  out_min,
  output logic [SIZE-1:0]  out_max,
  output logic [CNT_W-1:0] out_min_idx,
  output logic [CNT_W-1:0] out_max_idx,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [SIZE-1:0]  min_q, min_d, max_q, max_d;
  logic [CNT_W-1:0] min_idx_q, min_idx_d, max_idx_q, max_idx_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;

  logic a_eq, a_lt, a_gt;
  logic b_eq, b_lt, b_gt;
  logic unused_flags;

  comparator #(.SIZE(SIZE)) u_cmp_min (
    .a       (in_data),
    .b       (min_q),
    .equal   (a_eq),
    .lower   (a_lt),
    .greater (a_gt)
  );

  comparator #(.SIZE(SIZE)) u_cmp_max (
    .a       (in_data),
    .b       (max_q),
    .equal   (b_eq),
    .lower   (b_lt),
    .greater (b_gt)
  );

  // Ties and opposite-direction flags never update the accumulators.
  assign unused_flags = ^{a_eq, a_gt, b_eq, b_lt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      min_q     <= '0;
      max_q     <= '0;
      min_idx_q <= '0;
      max_idx_q <= '0;
      count_q   <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      max_q     <= max_d;
      min_idx_q <= min_idx_d;
      max_idx_q <= max_idx_d;
      count_q   <= count_d;
      sat_q     <= sat_d;
    end
  end

  // Next-state and accumulator update.
  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    max_d     = max_q;
    min_idx_d = min_idx_q;
    max_idx_d = max_idx_q;
    count_d   = count_q;
    sat_d     = sat_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          min_d     = in_data;
          max_d     = in_data;
          min_idx_d = '0;
          max_idx_d = '0;
          count_d   = CNT_W'(1);
          sat_d     = 1'b0;
          state_d   = in_last ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          if (a_lt) begin
            min_d     = in_data;
            min_idx_d = count_q;
          end
          if (b_gt) begin
            max_d     = in_data;
            max_idx_d = count_q;
          end
          if (count_q == CNT_MAX) begin
            sat_d = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
          if (in_last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          sat_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready    = (state_q == IDLE) || (state_q == ACCUM);
  assign out_valid   = (state_q == DONE);
  assign out_min     = min_q;
  assign out_max     = max_q;
  assign out_min_idx = min_idx_q;
  assign out_max_idx = max_idx_q;
  assign out_count   = count_q;
  assign out_sat     = sat_q;

endmodule

// File: tb/tb_comparator_minmax_stream.sv
// Directed bench: default-width DUT plus a CNT_W=2 DUT sharing one input stream.
module tb_comparator_minmax_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_sat;
  logic [31:0] out_min, out_max;
  logic [15:0] out_min_idx, out_max_idx, out_count;

  logic        s_in_ready, s_out_valid, s_out_sat;
  logic [31:0] s_out_min, s_out_max;
  logic [1:0]  s_out_min_idx, s_out_max_idx, s_out_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  comparator_minmax_stream dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_min(out_min), .out_max(out_max), .out_min_idx(out_min_idx),
    .out_max_idx(out_max_idx), .out_count(out_count), .out_sat(out_sat)
  );

  comparator_minmax_stream #(.SIZE(32), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_min(s_out_min), .out_max(s_out_max), .out_min_idx(s_out_min_idx),
    .out_max_idx(s_out_max_idx), .out_count(s_out_count), .out_sat(s_out_sat)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release: out_valid=%0b in_ready=%0b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    checks++;
    if ({in_ready, out_valid, out_sat} !== 3'b100) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%0b out_valid=%0b out_sat=%0b required 1/0/0",
               in_ready, out_valid, out_sat);
    end
    checks++;
    if ({out_min, out_max, out_min_idx, out_max_idx, out_count} !== '0) begin
      errors++;
      $display("FAIL reset_data: min=%h max=%h mi=%0d xi=%0d cnt=%0d required all 0",
               out_min, out_max, out_min_idx, out_max_idx, out_count);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    send_beat(32'd5, 1'b0);
    send_beat(32'd3, 1'b0);
    send_beat(32'd9, 1'b0);
    send_beat(32'd3, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency: out_valid=%0b in_ready=%0b required 1/0", out_valid, in_ready);
    end
    checks++;
    if ({out_min, out_min_idx, out_max, out_max_idx, out_count, out_sat} !==
        {32'd3, 16'd1, 32'd9, 16'd2, 16'd4, 1'b0}) begin
      errors++;
      $display("FAIL basic_result: min=%0d mi=%0d max=%0d xi=%0d cnt=%0d sat=%0b required 3/1/9/2/4/0",
               out_min, out_min_idx, out_max, out_max_idx, out_count, out_sat);
    end
    release_result();
  endtask

  task automatic test_single();
    send_beat(32'hFFFF_FFFF, 1'b1);
    checks++;
    if ({out_valid, out_min, out_max, out_min_idx, out_max_idx, out_count} !==
        {1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'd0, 16'd0, 16'd1}) begin
      errors++;
      $display("FAIL single: v=%0b min=%h max=%h mi=%0d xi=%0d cnt=%0d required 1/ffffffff/ffffffff/0/0/1",
               out_valid, out_min, out_max, out_min_idx, out_max_idx, out_count);
    end
    release_result();
  endtask

  task automatic test_unsigned_and_hold();
    send_beat(32'h8000_0000, 1'b0);
    send_beat(32'h0000_0001, 1'b1);
    checks++;
    if ({out_min, out_max, out_min_idx, out_max_idx} !== {32'd1, 32'h8000_0000, 16'd1, 16'd0}) begin
      errors++;
      $display("FAIL unsigned: min=%h max=%h mi=%0d xi=%0d required 00000001/80000000/1/0",
               out_min, out_max, out_min_idx, out_max_idx);
    end
    in_valid = 1'b1;
    in_data  = 32'h0000_0000;
    in_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({in_ready, out_valid, out_min, out_max, out_count} !==
          {1'b0, 1'b1, 32'd1, 32'h8000_0000, 16'd2}) begin
        errors++;
        $display("FAIL hold_%0d: rdy=%0b v=%0b min=%h max=%h cnt=%0d required 0/1/00000001/80000000/2",
                 i, in_ready, out_valid, out_min, out_max, out_count);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    release_result();
    send_beat(32'd7, 1'b1);
    checks++;
    if ({out_valid, out_min, out_max, out_count} !== {1'b1, 32'd7, 32'd7, 16'd1}) begin
      errors++;
      $display("FAIL after_hold: v=%0b min=%0d max=%0d cnt=%0d required 1/7/7/1",
               out_valid, out_min, out_max, out_count);
    end
    release_result();
  endtask

  task automatic test_saturation();
    send_beat(32'd4, 1'b0);
    send_beat(32'd1, 1'b0);
    send_beat(32'd2, 1'b0);
    send_beat(32'd3, 1'b0);
    send_beat(32'd0, 1'b1);
    checks++;
    if ({s_out_valid, s_out_count, s_out_sat, s_out_min, s_out_min_idx, s_out_max, s_out_max_idx} !==
        {1'b1, 2'd3, 1'b1, 32'd0, 2'd3, 32'd4, 2'd0}) begin
      errors++;
      $display("FAIL sat_small: v=%0b cnt=%0d sat=%0b min=%0d mi=%0d max=%0d xi=%0d required 1/3/1/0/3/4/0",
               s_out_valid, s_out_count, s_out_sat, s_out_min, s_out_min_idx, s_out_max, s_out_max_idx);
    end
    checks++;
    if ({out_count, out_sat, out_min, out_min_idx} !== {16'd5, 1'b0, 32'd0, 16'd4}) begin
      errors++;
      $display("FAIL sat_wide: cnt=%0d sat=%0b min=%0d mi=%0d required 5/0/0/4",
               out_count, out_sat, out_min, out_min_idx);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (s_out_sat !== 1'b0 || s_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL sat_clear: sat=%0b v=%0b required 0/0", s_out_sat, s_out_valid);
    end
  endtask

  task automatic test_abort();
    send_beat(32'd8, 1'b0);
    send_beat(32'd2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, out_min, out_max, out_min_idx, out_max_idx, out_count, out_sat} !==
        {1'b0, 1'b1, 32'd0, 32'd0, 16'd0, 16'd0, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL abort_reset: v=%0b rdy=%0b min=%0d max=%0d cnt=%0d required 0/1/0/0/0",
               out_valid, in_ready, out_min, out_max, out_count);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL abort_novalid_%0d: out_valid=%0b required 0", i, out_valid);
      end
    end
    send_beat(32'd6, 1'b1);
    checks++;
    if ({out_valid, out_min, out_max, out_count, out_min_idx, out_max_idx} !==
        {1'b1, 32'd6, 32'd6, 16'd1, 16'd0, 16'd0}) begin
      errors++;
      $display("FAIL abort_next: v=%0b min=%0d max=%0d cnt=%0d mi=%0d xi=%0d required 1/6/6/1/0/0",
               out_valid, out_min, out_max, out_count, out_min_idx, out_max_idx);
    end
    release_result();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_unsigned_and_hold();
    test_saturation();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/comparator_minmax_stream.md
# comparator_minmax_stream

Streaming consumer of the `comparator` flag interface: accepts a packet of unsigned SIZE-bit operands over a valid/ready handshake and tracks the running minimum and maximum. It also tracks the first-occurrence index of each and the element count. At end of packet it presents one result beat downstream. It sits after operand sources in the FPU datapath and is the standard sink for `equal`/`lower`/`greater` results.

## Interface
- SIZE, 32, operand width in bits
- CNT_W, 16, width of count and index fields
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  SIZE  unsigned operand
- in_last  in  1  beat is last of packet
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts result
- out_min  out  SIZE  smallest operand in packet
- out_max  out  SIZE  largest operand in packet
- out_min_idx  out  CNT_W  0-based index of first occurrence of min
- out_max_idx  out  CNT_W  0-based index of first occurrence of max
- out_count  out  CNT_W  number of beats in packet, saturating
- out_sat  out  1  packet length exceeded 2^CNT_W-1

## Operation
- States: IDLE (no beat of current packet yet), ACCUM (>=1 beat taken), DONE (result held).
- in_ready = 1 in IDLE and ACCUM, 0 in DONE; decoded from state only, never from out_ready.
- Accept = in_valid && in_ready.
- Accept in IDLE:
  - min = max = in_data; min_idx = max_idx = 0; count = 1; sat = 0.
  - Next state is DONE if in_last, else ACCUM.
- Accept in ACCUM, with idx = current count:
  - Instance A compares (a=in_data, b=min). If lower, then min = in_data and min_idx = idx.
  - Instance B compares (a=in_data, b=max). If greater, then max = in_data and max_idx = idx.
  - Ties (equal) keep the stored value and index, so the first occurrence wins.
  - count increments.
  - Next state is DONE if in_last.
- Saturation:
  - When count = 2^CNT_W-1, count holds and sat sets.
  - Indices of later beats use the saturated value.
  - Comparisons continue.
- DONE: out_valid = 1. All out_* stay stable until out_valid && out_ready; then go to IDLE and clear sat.
- Comparison is unsigned, full SIZE bits. No sign or float interpretation.

## Timing
- Reset (async assert, sync-safe deassert):
  - state = IDLE; in_ready = 1; out_valid = 0.
  - out_min, out_max, out_min_idx, out_max_idx, out_count = 0; out_sat = 0.
- Throughput: one beat per cycle while in IDLE/ACCUM.
- Latency: last beat accepted at edge N, so out_valid = 1 from edge N.
- The result is registered, with no combinational path from in_* to out_*.
- Single-beat packet: IDLE accept with in_last goes directly to DONE; count = 1, both indices = 0.
- Back-to-back packets: at least one cycle of in_ready = 0 between packets, namely the DONE cycle(s).
- out_ready high in the first DONE cycle gives a 1-cycle DONE. in_ready returns the cycle after.
- in_valid while in DONE: not accepted, and data must be held by the source.
- rst_n asserted mid-packet or in DONE: partial result is discarded immediately and all outputs return to reset values. No result beat is emitted for the aborted packet.
- out_* values outside DONE are the internal accumulators. They are not meaningful and downstream must ignore them.

## Structure
- Shared package/header:
  - State encodings: IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2.
  - Default SIZE/CNT_W constants, shared with other FPU basics.
- Two instances of the existing `comparator` sub-module (SIZE passed through), against min and max respectively. No new comparison logic.
- One FSM plus accumulator registers in this module. No other sub-modules.

## Test plan
- Reset then packet 5, 3, 9, 3(last) -> out_valid next edge; min = 3, min_idx = 1, max = 9, max_idx = 2, count = 4, sat = 0.
- Single beat 0xFFFFFFFF with last -> min = max = 0xFFFFFFFF, both idx = 0, count = 1.
- Unsigned check: 0x80000000, 0x00000001(last) -> min = 1, max = 0x80000000.
- out_ready held low 10 cycles in DONE with in_valid high -> in_ready = 0, outputs stable.
- Release out_ready -> IDLE, next packet 7(last) gives min = max = 7.
- CNT_W = 2, packet of 5 beats 4, 1, 2, 3, 0(last) -> count = 3, sat = 1, min = 0, min_idx = 3.
- rst_n pulsed after 2 beats of 8, 2 -> outputs zero, no out_valid.
- Following packet 6(last) -> min = max = 6, count = 1.
